muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle multiply/divide controller that owns the Hi/Lo registers of the EX stage.
//  Accepts MULT/MULTU/DIV/DIVU from ID/EX, runs a WIDTH-step shift-add / restoring-divide loop,
//  and writes Hi/Lo. Requests a pipeline stall while a second mul/div or an MFHI/MFLO is
//  blocked behind an in-flight operation.
// PARAMETERS
//  WIDTH   32   operand width; Hi/Lo are WIDTH bits each; iteration count = WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  Reset      in   1      asynchronous, active-low reset (0 = reset)
//  start      in   1      mul/div op present in EX this cycle
//  op         in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  rs_val     in   WIDTH  forwarded operand A (multiplicand / dividend)
//  rt_val     in   WIDTH  forwarded operand B (multiplier / divisor)
//  hilo_read  in   1      MFHI/MFLO present in EX this cycle
//  flush      in   1      synchronous abort of the in-flight operation
//  hi_out     out  WIDTH  Hi register
//  lo_out     out  WIDTH  Lo register
//  busy       out  1      operation in progress (state CALC or FIX)
//  stall_req  out  1      combinational: busy & (start | hilo_read)
//  done       out  1      one-cycle pulse: Hi/Lo updated on the preceding edge
//  div0       out  1      sticky until next accepted start: last DIV/DIVU had rt_val == 0
// BEHAVIOUR
//  Reset (Reset=0, async): state=IDLE; hi_out=lo_out=0; busy=0; done=0; div0=0; counter=0.
//  FSM: IDLE -> CALC on start (accepted only in IDLE). CALC -> FIX after WIDTH iterations.
//  FIX -> IDLE.
//  - IDLE: edge with start=1 latches op, |rs|, |rt| (signed ops only; unsigned taken as-is),
//    result signs, raw rs_val; counter=WIDTH-1.
//  - CALC: one multiply (add-shift) or divide (shift-subtract-restore) step per edge;
//    counter decrements; leaves CALC on the edge where counter==0.
//  - FIX: applies sign correction, then writes hi_out/lo_out on its edge; done=1 next cycle.
//  Latency: start sampled at edge E0 -> Hi/Lo valid and done=1 after edge E0+WIDTH+1.
//  busy falls in the same cycle. hi_out/lo_out hold their old value until that edge.
//  Arithmetic:
//  - MULT/MULTU: {hi,lo} = full 2*WIDTH product (signed/unsigned).
//  - DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with sign of dividend.
//  - DIV of -2^(WIDTH-1) by -1: lo = 0x80000000, hi = 0 (no trap).
//  - rt_val==0 for DIV/DIVU: lo = all ones, hi = rs_val unchanged; div0=1; latency unchanged.
//  Simultaneous events:
//  - start while busy: not accepted; stall_req=1 holds it in EX until the IDLE cycle.
//  - start in the cycle done=1: accepted (state is IDLE).
//  - hilo_read while busy: stall_req=1; when idle, hi_out/lo_out are read directly.
//  - flush=1 in CALC/FIX: state->IDLE next edge; Hi/Lo and div0 unchanged; no done pulse.
//    flush has priority over start in the same cycle.
//  - Reset asserted mid-operation: immediate return to reset values; result discarded.
//  - start with op changing while stalled: only op/operands present at the accepting edge are used.
// TESTING
//  1 MULT rs=0xFFFFFFFF rt=0x00000002 -> hi=0xFFFFFFFF lo=0xFFFFFFFE; done exactly 33 cycles
//    after the start edge.
//  2 MULTU rs=0xFFFFFFFF rt=0x00000002 -> hi=0x00000001 lo=0xFFFFFFFE.
//  3 DIV rs=-7 (0xFFFFFFF9) rt=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF;
//    DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000 hi=0.
//  4 DIVU rs=100 rt=0 -> lo=0xFFFFFFFF hi=0x00000064 div0=1;
//    next DIVU 100/7 -> lo=14 hi=2 div0=0.
//  5 Back-to-back MULT plus hilo_read during busy -> stall_req=1 every busy cycle;
//    second op starts the cycle after the first done; MFLO sees the first result.
//  6 Reset low 10 cycles into a MULT -> all outputs 0 immediately;
//    flush 10 cycles into a DIV -> Hi/Lo keep prior values, no done pulse, busy=0 next cycle.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit owning the EX-stage Hi/Lo registers.
// Signed operands are reduced to magnitudes, iterated WIDTH times, then sign-fixed in FIX.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hilo_read,
  input  logic             flush,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic             div0
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  // Operation context captured at the accepting edge.
  typedef struct packed {
    logic             isDiv;
    logic             negLo;    // product sign (mul) or quotient sign (div)
    logic             negHi;    // remainder takes the dividend's sign
    logic             divZero;
    logic [WIDTH-1:0] rawRs;
    logic [WIDTH-1:0] opA;      // multiplicand magnitude or divisor magnitude
  } opCtx_t;

  state_t          state;
  logic [CW-1:0]   count;
  opCtx_t          ctx;
  logic [WIDTH:0]  rem;
  logic [WIDTH-1:0] quo;

  logic             isSigned, rsNeg, rtNeg;
  logic [WIDTH-1:0] rsAbs, rtAbs;
  logic [WIDTH:0]   mulSum, shifted, diff;
  logic [2*WIDTH-1:0] prod, prodFix;
  logic [WIDTH-1:0] qFix, rFix;

  always_comb begin
    isSigned = ~op[0];
    rsNeg    = isSigned & rs_val[WIDTH-1];
    rtNeg    = isSigned & rt_val[WIDTH-1];
    rsAbs    = rsNeg ? -rs_val : rs_val;
    rtAbs    = rtNeg ? -rt_val : rt_val;

    mulSum   = {1'b0, rem[WIDTH-1:0]} + ({(WIDTH+1){quo[0]}} & {1'b0, ctx.opA});
    shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff     = shifted - {1'b0, ctx.opA};

    prod     = {rem[WIDTH-1:0], quo};
    prodFix  = ctx.negLo ? -prod : prod;
    qFix     = ctx.negLo ? -quo : quo;
    rFix     = ctx.negHi ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  assign busy      = (state != IDLE);
  assign stall_req = busy & (start | hilo_read);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      count  <= '0;
      ctx    <= '0;
      rem    <= '0;
      quo    <= '0;
      hi_out <= '0;
      lo_out <= '0;
      done   <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            state       <= CALC;
            count       <= CW'(WIDTH-1);
            div0        <= 1'b0;
            ctx.isDiv   <= op[1];
            ctx.negLo   <= rsNeg ^ rtNeg;
            ctx.negHi   <= rsNeg;
            ctx.divZero <= (rt_val == '0);
            ctx.rawRs   <= rs_val;
            ctx.opA     <= op[1] ? rtAbs : rsAbs;
            rem         <= '0;
            quo         <= op[1] ? rsAbs : rtAbs;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            if (ctx.isDiv) begin
              // Restoring step: keep the subtraction only when it did not borrow.
              rem <= diff[WIDTH] ? shifted : diff;
              quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
              rem <= {1'b0, mulSum[WIDTH:1]};
              quo <= {mulSum[0], quo[WIDTH-1:1]};
            end
            count <= count - 1'b1;
            if (count == '0) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (!ctx.isDiv) begin
              hi_out <= prodFix[2*WIDTH-1:WIDTH];
              lo_out <= prodFix[WIDTH-1:0];
            end else if (ctx.divZero) begin
              hi_out <= ctx.rawRs;
              lo_out <= '1;
              div0   <= 1'b1;
            end else begin
              hi_out <= rFix;
              lo_out <= qFix;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
